// File: rtl/sfx_pkg.sv
// Shared types, effect table constants and half-period helper for the SFX sequencer.
package sfx_pkg;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_PLAY = 2'd2, S_GAP = 2'd3} state_t;

  // Codes double as priority: a larger code wins.
  typedef enum logic [1:0] {SFX_NONE = 2'd0, SFX_JUMP = 2'd1, SFX_POINT = 2'd2, SFX_CRASH = 2'd3} sfx_t;

  localparam int DUR_W = 8;
  localparam int IDX_W = 2;

  localparam int N_JUMP  = 1;
  localparam int N_POINT = 2;
  localparam int N_CRASH = 3;

  localparam int F_JUMP0  = 450;  localparam int D_JUMP0  = 60;
  localparam int F_POINT0 = 880;  localparam int D_POINT0 = 50;
  localparam int F_POINT1 = 1320; localparam int D_POINT1 = 80;
  localparam int F_CRASH0 = 300;  localparam int D_CRASH0 = 100;
  localparam int F_CRASH1 = 200;  localparam int D_CRASH1 = 100;
  localparam int F_CRASH2 = 120;  localparam int D_CRASH2 = 200;

  function automatic int unsigned half_period_of(input int unsigned clk_hz, input int unsigned f);
    return clk_hz / (2 * f);
  endfunction

endpackage

// File: rtl/sfx_rom.sv
// Combinational effect table: (sfx_id, note_idx) -> half period, duration in ticks, last-note flag.
module sfx_rom
  import sfx_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int HP_W   = 18
) (
  input  sfx_t             i_id,
  input  logic [IDX_W-1:0] i_idx,
  output logic [HP_W-1:0]  o_hp,
  output logic [DUR_W-1:0] o_dur,
  output logic             o_last
);

  localparam logic [HP_W-1:0] HP_J0 = HP_W'(half_period_of(CLK_HZ, F_JUMP0));
  localparam logic [HP_W-1:0] HP_P0 = HP_W'(half_period_of(CLK_HZ, F_POINT0));
  localparam logic [HP_W-1:0] HP_P1 = HP_W'(half_period_of(CLK_HZ, F_POINT1));
  localparam logic [HP_W-1:0] HP_C0 = HP_W'(half_period_of(CLK_HZ, F_CRASH0));
  localparam logic [HP_W-1:0] HP_C1 = HP_W'(half_period_of(CLK_HZ, F_CRASH1));
  localparam logic [HP_W-1:0] HP_C2 = HP_W'(half_period_of(CLK_HZ, F_CRASH2));

  always_comb begin
    o_hp   = '0;
    o_dur  = '0;
    o_last = 1'b1;
    case (i_id)
      SFX_JUMP: begin
        o_hp   = HP_J0;
        o_dur  = DUR_W'(D_JUMP0);
        o_last = (int'(i_idx) >= N_JUMP - 1);
      end
      SFX_POINT: begin
        if (i_idx == IDX_W'(0)) begin
          o_hp  = HP_P0;
          o_dur = DUR_W'(D_POINT0);
        end else begin
          o_hp  = HP_P1;
          o_dur = DUR_W'(D_POINT1);
        end
        o_last = (int'(i_idx) >= N_POINT - 1);
      end
      SFX_CRASH: begin
        case (i_idx)
          IDX_W'(0): begin o_hp = HP_C0; o_dur = DUR_W'(D_CRASH0); end
          IDX_W'(1): begin o_hp = HP_C1; o_dur = DUR_W'(D_CRASH1); end
          default:   begin o_hp = HP_C2; o_dur = DUR_W'(D_CRASH2); end
        endcase
        o_last = (int'(i_idx) >= N_CRASH - 1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Game-event sound-effect sequencer: event pulses -> timed note sequence for the tone stage.
// Optional build macro SFX_PREEMPT_EN lets equal/higher-priority events restart a running effect.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int HP_W    = 18
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  input  logic            ev_jump,
  input  logic            ev_point,
  input  logic            ev_crash,
  input  logic            mute,
  output logic            tone_on,
  output logic [HP_W-1:0] half_period,
  output logic            busy,
  output logic [1:0]      sfx_id
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  state_t           r_state, w_next;
  sfx_t             r_sfx, w_next_sfx, w_ev_id;
  logic [IDX_W-1:0] r_idx, w_next_idx;
  logic [PW-1:0]    r_pre;
  logic [DUR_W-1:0] r_dur_cnt, r_dur;
  logic             r_last, r_tone, r_busy;
  logic [HP_W-1:0]  r_hp;
  logic [HP_W-1:0]  w_rom_hp;
  logic [DUR_W-1:0] w_rom_dur;
  logic             w_rom_last, w_ev, w_tick, w_expire, w_accept;

  assign w_ev_id  = ev_crash ? SFX_CRASH : ev_point ? SFX_POINT : ev_jump ? SFX_JUMP : SFX_NONE;
  assign w_ev     = ev_crash | ev_point | ev_jump;
  assign w_tick   = (r_pre == PW'(DIV - 1));
  assign w_expire = (r_state == S_PLAY) && w_tick && (r_dur_cnt == r_dur - DUR_W'(1));

  sfx_rom #(.CLK_HZ(CLK_HZ), .HP_W(HP_W)) u_rom (
    .i_id  (r_sfx),
    .i_idx (r_idx),
    .o_hp  (w_rom_hp),
    .o_dur (w_rom_dur),
    .o_last(w_rom_last)
  );

  always_comb begin
    w_next     = r_state;
    w_next_sfx = r_sfx;
    w_next_idx = r_idx;
    w_accept   = 1'b0;
    case (r_state)
      S_LOAD: w_next = S_PLAY;
      S_PLAY: if (w_expire) w_next = r_last ? S_IDLE : S_GAP;
      S_GAP:  if (w_tick) begin
        w_next     = S_LOAD;
        w_next_idx = r_idx + IDX_W'(1);
      end
      default: ;
    endcase
    if (w_next == S_IDLE) begin
      w_next_sfx = SFX_NONE;
      w_next_idx = '0;
    end
    // Testing w_next (not r_state) lets a pulse on the final-note expiry start a new effect.
`ifdef SFX_PREEMPT_EN
    w_accept = w_ev && ((w_next == S_IDLE) || ((r_state != S_IDLE) && (w_ev_id >= r_sfx)));
`else
    w_accept = w_ev && (w_next == S_IDLE);
`endif
    if (w_accept) begin
      w_next     = S_LOAD;
      w_next_sfx = w_ev_id;
      w_next_idx = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_sfx     <= SFX_NONE;
      r_idx     <= '0;
      r_pre     <= '0;
      r_dur_cnt <= '0;
      r_dur     <= '0;
      r_last    <= 1'b0;
      r_hp      <= '0;
      r_tone    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sfx   <= w_next_sfx;
      r_idx   <= w_next_idx;
      if ((w_next != r_state) || ((r_state != S_PLAY) && (r_state != S_GAP)) || w_tick)
        r_pre <= '0;
      else
        r_pre <= r_pre + PW'(1);
      if ((w_next != S_PLAY) || (r_state != S_PLAY))
        r_dur_cnt <= '0;
      else if (w_tick)
        r_dur_cnt <= r_dur_cnt + DUR_W'(1);
      // Note parameters change only on LOAD->PLAY, so the tone stage never sees a mid-note step.
      if ((r_state == S_LOAD) && (w_next == S_PLAY)) begin
        r_hp   <= w_rom_hp;
        r_dur  <= w_rom_dur;
        r_last <= w_rom_last;
      end
      r_tone <= (w_next == S_PLAY) && !mute;
      r_busy <= (w_next != S_IDLE);
    end
  end

  assign tone_on     = r_tone;
  assign half_period = r_hp;
  assign busy        = r_busy;
  assign sfx_id      = r_sfx;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench: per-cycle compare against a timeline model built from the effect table.
module tb_sfx_sequencer;

  localparam int CLK = 50_000_000;
  localparam int TCK = 10_000_000;
  localparam int TK  = CLK / TCK;
`ifdef SFX_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        ev_jump = 1'b0, ev_point = 1'b0, ev_crash = 1'b0, mute = 1'b0;
  logic        tone_on, busy;
  logic [17:0] half_period;
  logic [1:0]  sfx_id;

  sfx_sequencer #(.CLK_HZ(CLK), .TICK_HZ(TCK), .HP_W(18)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .ev_jump(ev_jump), .ev_point(ev_point),
    .ev_crash(ev_crash), .mute(mute), .tone_on(tone_on), .half_period(half_period),
    .busy(busy), .sfx_id(sfx_id)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_assert = 0, n_fail = 0;
  bit chk_en = 1'b0;

  // Effect table as frequencies/durations; the model derives expected outputs cycle by cycle.
  int fr[4][3] = '{'{0, 0, 0}, '{450, 0, 0}, '{880, 1320, 0}, '{300, 200, 120}};
  int du[4][3] = '{'{0, 0, 0}, '{60, 0, 0}, '{50, 80, 0}, '{100, 100, 200}};
  int nn[4]    = '{0, 1, 2, 3};

  typedef struct { bit busy; int id; bit play; int hp; } ent_t;
  ent_t q[$];
  ent_t cur;
  int   last_hp;
  bit   exp_tone;

  function automatic void build(input int id);
    q.delete();
    for (int i = 0; i < nn[id]; i++) begin
      q.push_back('{1'b1, id, 1'b0, 0});
      for (int k = 0; k < du[id][i] * TK; k++) q.push_back('{1'b1, id, 1'b1, CLK / (2 * fr[id][i])});
      if (i != nn[id] - 1)
        for (int k = 0; k < TK; k++) q.push_back('{1'b1, id, 1'b0, 0});
    end
  endfunction

  task automatic model_step();
    int eid;
    bit acc;
    if (!reset_n) begin
      q.delete();
      cur = '{1'b0, 0, 1'b0, 0};
      last_hp = 0;
      exp_tone = 1'b0;
    end else begin
      eid = ev_crash ? 3 : ev_point ? 2 : ev_jump ? 1 : 0;
      acc = (eid != 0) && ((q.size() == 0) || (PREEMPT && cur.busy && eid >= cur.id));
      if (acc) build(eid);
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{1'b0, 0, 1'b0, 0};
      if (cur.play) last_hp = cur.hp;
      exp_tone = cur.play && !mute;
    end
  endtask

  initial begin
    cur = '{1'b0, 0, 1'b0, 0};
    last_hp = 0;
    exp_tone = 1'b0;
    forever begin
      @(posedge CLOCK_50 or negedge reset_n);
      model_step();
    end
  end

  initial forever begin
    @(negedge CLOCK_50);
    if (reset_n && chk_en) begin
      n_assert++;
      if (tone_on !== exp_tone || busy !== cur.busy || int'(sfx_id) != cur.id ||
          int'(half_period) != last_hp) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got tone=%0b busy=%0b id=%0d hp=%0d exp tone=%0b busy=%0b id=%0d hp=%0d",
                 $time, tone_on, busy, sfx_id, half_period, exp_tone, cur.busy, cur.id, last_hp);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input bit j, input bit p, input bit c);
    @(negedge CLOCK_50);
    ev_jump = j; ev_point = p; ev_crash = c;
    @(negedge CLOCK_50);
    ev_jump = 0; ev_point = 0; ev_crash = 0;
  endtask

  task automatic count_tone(output int n);
    n = 0;
    while (tone_on && n < 10000) begin n++; @(negedge CLOCK_50); end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin n++; @(negedge CLOCK_50); end
    chk("wait_idle", int'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, i, tc;
    int hv[$];
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_tone", int'(tone_on), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_id", int'(sfx_id), 0);
    chk("rst_hp", int'(half_period), 0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    // jump from idle
    pulse(1, 0, 0);
    chk("jump_load_busy", int'(busy), 1);
    chk("jump_load_id", int'(sfx_id), 1);
    chk("jump_load_tone", int'(tone_on), 0);
    @(negedge CLOCK_50);
    chk("jump_hp", int'(half_period), 55555);
    count_tone(n);
    chk("jump_len", n, 300);
    chk("jump_end_busy", int'(busy), 0);
    chk("jump_end_id", int'(sfx_id), 0);
    chk("jump_hp_hold", int'(half_period), 55555);
    repeat (4) @(negedge CLOCK_50);

    // point: two notes with gap + load between
    pulse(0, 1, 0);
    @(negedge CLOCK_50);
    chk("point_hp0", int'(half_period), 28409);
    count_tone(n);
    chk("point_len0", n, 250);
    n = 0;
    while (!tone_on && busy && n < 1000) begin n++; @(negedge CLOCK_50); end
    chk("point_gap", n, 6);
    chk("point_hp1", int'(half_period), 18939);
    count_tone(n);
    chk("point_len1", n, 400);
    chk("point_end_busy", int'(busy), 0);
    repeat (4) @(negedge CLOCK_50);

    // simultaneous jump + crash: crash wins
    pulse(1, 0, 1);
    chk("prio_id", int'(sfx_id), 3);
    n = 0;
    while (busy && n < 20000) begin
      if (tone_on && (hv.size() == 0 || hv[$] != int'(half_period))) hv.push_back(int'(half_period));
      n++;
      @(negedge CLOCK_50);
    end
    chk("crash_notes", hv.size(), 3);
    chk("crash_hp0", (hv.size() > 0) ? hv[0] : -1, 83333);
    chk("crash_hp1", (hv.size() > 1) ? hv[1] : -1, 125000);
    chk("crash_hp2", (hv.size() > 2) ? hv[2] : -1, 208333);
    repeat (4) @(negedge CLOCK_50);

    // crash during jump note
    pulse(1, 0, 0);
    @(negedge CLOCK_50);
    n = 0;
    while (tone_on && n < 1000) begin
      n++;
      ev_crash = (n == 100);
      @(negedge CLOCK_50);
    end
    ev_crash = 1'b0;
    chk("preempt_jump_len", n, PREEMPT ? 100 : 300);
    chk("preempt_id", int'(sfx_id), PREEMPT ? 3 : 0);
    wait_idle();
    repeat (4) @(negedge CLOCK_50);

    // jump during crash: always ignored
    pulse(0, 0, 1);
    @(negedge CLOCK_50);
    n = 0;
    while (tone_on && n < 1000) begin
      n++;
      ev_jump = (n == 50);
      @(negedge CLOCK_50);
    end
    ev_jump = 1'b0;
    chk("lowprio_crash_len", n, 500);
    chk("lowprio_id", int'(sfx_id), 3);
    wait_idle();
    repeat (4) @(negedge CLOCK_50);

    // mute window over note cycles 50..99
    pulse(1, 0, 0);
    @(negedge CLOCK_50);
    i = 0; tc = 0;
    while (busy && i < 1000) begin
      if (tone_on) tc++;
      mute = (i + 1 >= 50 && i + 1 <= 99);
      i++;
      @(negedge CLOCK_50);
    end
    mute = 1'b0;
    chk("mute_tone_cycles", tc, 250);
    chk("mute_note_len", i, 300);
    repeat (4) @(negedge CLOCK_50);

    // async reset in crash note 2
    pulse(0, 0, 1);
    n = 0;
    while (!(tone_on && int'(half_period) == 125000) && n < 5000) begin n++; @(negedge CLOCK_50); end
    chk("reach_crash2", int'(half_period), 125000);
    repeat (30) @(negedge CLOCK_50);
    #3 reset_n = 1'b0;
    #1;
    chk("async_tone", int'(tone_on), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_id", int'(sfx_id), 0);
    chk("async_hp", int'(half_period), 0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_id", int'(sfx_id), 0);

    // random traffic against the model
    for (int c = 0; c < 15000; c++) begin
      int r;
      @(negedge CLOCK_50);
      r = $urandom_range(0, 299);
      ev_jump  = (r == 0) || (r == 3);
      ev_point = (r == 1) || (r == 3);
      ev_crash = (r == 2) || (r == 4);
      if ($urandom_range(0, 99) == 0) mute = ~mute;
    end
    @(negedge CLOCK_50);
    ev_jump = 0; ev_point = 0; ev_crash = 0; mute = 0;
    repeat (5) @(negedge CLOCK_50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
